// File: rtl/pdp8_pkg.sv
// Shared types and constants for the PDP-8 operate group 1 sequencer.
// Holds the FSM state enum, IR bit positions and the decoded-instruction record.
package pdp8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_CMP  = 3'd2,
    ST_INC  = 3'd3,
    ST_ROT1 = 3'd4,
    ST_ROT2 = 3'd5,
    ST_FIN  = 3'd6
  } state_e;

  // IR is numbered LSB-first, so PDP bit 0 is IR[11]
  localparam int IR_CLA = 7;
  localparam int IR_CLL = 6;
  localparam int IR_CMA = 5;
  localparam int IR_CML = 4;
  localparam int IR_RAR = 3;
  localparam int IR_RAL = 2;
  localparam int IR_BSW = 1;
  localparam int IR_IAC = 0;

  localparam logic [3:0] OPR1_OPCODE = 4'b1110;

  // en[0..4] = CLR, CMP, INC, ROT1, ROT2 step enables
  typedef struct packed {
    logic [4:0] en;
    logic       cla;
    logic       cll;
    logic       cma;
    logic       cml;
    logic       rot_left;
    logic       rot_bsw;
  } opr1_dec_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic ac_clr;
    logic ac_cma;
    logic ac_inc;
    logic rot_r;
    logic rot_l;
    logic rot_bsw;
    logic cll;
    logic cml;
    logic set;
    logic ac_ck;
    logic link_ck;
  } opr1_out_t;

  // First enabled step strictly after cur; FIN when none remain.
  function automatic state_e next_step(input state_e cur, input logic [4:0] en);
    next_step = ST_FIN;
    for (int i = 4; i >= 0; i--) begin
      if (en[i] && ((i + 1) > int'(cur))) next_step = state_e'(3'(i + 1));
    end
  endfunction

endpackage

// File: rtl/opr1_decode.sv
// Combinational decode of a group 1 operate instruction into step enables,
// rotate direction and the raw clear/complement selects.
module opr1_decode
  import pdp8_pkg::*;
(
  input  logic [11:0] IR,
  output opr1_dec_t   dec
);

  logic legal;
  logic rar;
  logic ral;
  logic two;
  logic single_rot;
  logic bsw_only;

  always_comb begin
    legal      = (IR[11:8] == OPR1_OPCODE);
    rar        = IR[IR_RAR];
    ral        = IR[IR_RAL];
    two        = IR[IR_BSW];
    single_rot = rar ^ ral;
    // IR[1] without a direction means byte swap; with both directions it is void
    bsw_only   = two && !rar && !ral;

    dec          = '0;
    dec.cla      = legal && IR[IR_CLA];
    dec.cll      = legal && IR[IR_CLL];
    dec.cma      = legal && IR[IR_CMA];
    dec.cml      = legal && IR[IR_CML];
    dec.rot_left = ral;
    dec.rot_bsw  = bsw_only;
    dec.en[0]    = legal && (IR[IR_CLA] || IR[IR_CLL]);
    dec.en[1]    = legal && (IR[IR_CMA] || IR[IR_CML]);
    dec.en[2]    = legal && IR[IR_IAC];
    dec.en[3]    = legal && (single_rot || bsw_only);
    dec.en[4]    = legal && single_rot && two;
  end

endmodule

// File: rtl/opr1_sequencer.sv
// Orders group 1 micro-operations as clear, complement, increment, rotate;
// each step is a SETUP cycle (levels) then a STROBE cycle (levels + clocks).
module opr1_sequencer
  import pdp8_pkg::*;
(
  input  logic        SYSCLK,
  input  logic        CLEAR_N,
  input  logic        START,
  input  logic [11:0] IR,
  input  logic        INC_CARRY,
  output logic        BUSY,
  output logic        DONE,
  output logic        AC_CLR,
  output logic        AC_CMA,
  output logic        AC_INC,
  output logic        ROT_R,
  output logic        ROT_L,
  output logic        ROT_BSW,
  output logic        CLL,
  output logic        CML,
  output logic        SET,
  output logic        AC_CK,
  output logic        LINK_CK,
  output logic [2:0]  DBG_STATE
);

  state_e    state_q, state_d;
  logic      phase_q, phase_d;
  opr1_dec_t dec_new, dec_q, dec_d;
  opr1_out_t out_q, out_d;
  logic      accept;

  opr1_decode u_decode (
    .IR  (IR),
    .dec (dec_new)
  );

  // A request is taken when idle or in the FIN cycle, which allows back-to-back.
  assign accept = START && ((state_q == ST_IDLE) || (state_q == ST_FIN));
  assign dec_d  = accept ? dec_new : dec_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = next_step(ST_IDLE, dec_new.en);
          phase_d = 1'b0;
        end
      end
      ST_FIN: begin
        phase_d = 1'b0;
        state_d = START ? next_step(ST_IDLE, dec_new.en) : ST_IDLE;
      end
      default: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          state_d = next_step(state_q, dec_q.en);
        end
      end
    endcase
  end

  // Outputs are computed for the upcoming state and registered, so strobes are glitch-free.
  always_comb begin
    out_d      = '0;
    out_d.busy = (state_d != ST_IDLE);
    case (state_d)
      ST_CLR: begin
        out_d.ac_clr  = dec_d.cla;
        out_d.cll     = dec_d.cll;
        out_d.ac_ck   = phase_d && dec_d.cla;
        out_d.link_ck = phase_d && dec_d.cll;
      end
      ST_CMP: begin
        out_d.ac_cma  = dec_d.cma;
        out_d.cml     = dec_d.cml;
        out_d.ac_ck   = phase_d && dec_d.cma;
        out_d.link_ck = phase_d && dec_d.cml;
      end
      ST_INC: begin
        // Carry is taken from the AC as it stands at the end of SETUP
        out_d.ac_inc  = 1'b1;
        out_d.ac_ck   = phase_d;
        out_d.cml     = phase_d && INC_CARRY;
        out_d.link_ck = phase_d && INC_CARRY;
      end
      ST_ROT1, ST_ROT2: begin
        out_d.ac_ck = phase_d;
        if (dec_d.rot_bsw) begin
          out_d.rot_bsw = 1'b1;
        end else begin
          out_d.rot_l   = dec_d.rot_left;
          out_d.rot_r   = !dec_d.rot_left;
          out_d.set     = 1'b1;
          out_d.link_ck = phase_d;
        end
      end
      ST_FIN: out_d.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (!CLEAR_N) begin
      state_q <= ST_IDLE;
      phase_q <= 1'b0;
      dec_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      dec_q   <= dec_d;
      out_q   <= out_d;
    end
  end

  assign BUSY      = out_q.busy;
  assign DONE      = out_q.done;
  assign AC_CLR    = out_q.ac_clr;
  assign AC_CMA    = out_q.ac_cma;
  assign AC_INC    = out_q.ac_inc;
  assign ROT_R     = out_q.rot_r;
  assign ROT_L     = out_q.rot_l;
  assign ROT_BSW   = out_q.rot_bsw;
  assign CLL       = out_q.cll;
  assign CML       = out_q.cml;
  assign SET       = out_q.set;
  assign AC_CK     = out_q.ac_ck;
  assign LINK_CK   = out_q.link_ck;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_opr1_sequencer.sv
// Bench for opr1_sequencer: directed instructions with hand-written per-cycle
// output vectors, checked by a negedge monitor against a timestamped queue.
module tb_opr1_sequencer;

  localparam int W = 45;

  localparam logic [12:0] M_BUSY = 13'h1000;
  localparam logic [12:0] M_DONE = 13'h0800;
  localparam logic [12:0] M_CLR  = 13'h0400;
  localparam logic [12:0] M_CMA  = 13'h0200;
  localparam logic [12:0] M_INC  = 13'h0100;
  localparam logic [12:0] M_ROTR = 13'h0080;
  localparam logic [12:0] M_ROTL = 13'h0040;
  localparam logic [12:0] M_BSW  = 13'h0020;
  localparam logic [12:0] M_CLL  = 13'h0010;
  localparam logic [12:0] M_CML  = 13'h0008;
  localparam logic [12:0] M_SET  = 13'h0004;
  localparam logic [12:0] M_ACK  = 13'h0002;
  localparam logic [12:0] M_LK   = 13'h0001;

  logic        SYSCLK = 1'b0;
  logic        CLEAR_N = 1'b0;
  logic        START = 1'b0;
  logic [11:0] IR = '0;
  logic        INC_CARRY = 1'b0;
  logic        BUSY, DONE, AC_CLR, AC_CMA, AC_INC, ROT_R, ROT_L, ROT_BSW;
  logic        CLL, CML, SET, AC_CK, LINK_CK;
  logic [2:0]  DBG_STATE;

  logic [12:0]  outs;
  logic [W-1:0] exp_q[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           c0, c1;

  opr1_sequencer dut (
    .SYSCLK    (SYSCLK),
    .CLEAR_N   (CLEAR_N),
    .START     (START),
    .IR        (IR),
    .INC_CARRY (INC_CARRY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .AC_CLR    (AC_CLR),
    .AC_CMA    (AC_CMA),
    .AC_INC    (AC_INC),
    .ROT_R     (ROT_R),
    .ROT_L     (ROT_L),
    .ROT_BSW   (ROT_BSW),
    .CLL       (CLL),
    .CML       (CML),
    .SET       (SET),
    .AC_CK     (AC_CK),
    .LINK_CK   (LINK_CK),
    .DBG_STATE (DBG_STATE)
  );

  assign outs = {BUSY, DONE, AC_CLR, AC_CMA, AC_INC, ROT_R, ROT_L, ROT_BSW,
                 CLL, CML, SET, AC_CK, LINK_CK};

  // clock / reset
  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  // monitor: every cycle with any output high is an event to match
  always @(negedge SYSCLK) begin
    logic [W-1:0] e;
    if (outs != 13'h0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: got unexpected cyc=%0d out=%b, expected no output", cyc, outs);
      end else begin
        e = exp_q.pop_front();
        if (e != {32'(cyc), outs}) begin
          errors++;
          $display("FAIL event: got cyc=%0d out=%b, expected cyc=%0d out=%b",
                   cyc, outs, e[W-1:13], e[12:0]);
        end
      end
    end
  end

  // driver helpers
  task automatic push(input int c, input int k, input logic [12:0] v);
    exp_q.push_back({32'(c + k), v});
  endtask

  // Called at a negedge; holds START for one cycle then scrambles IR.
  task automatic issue(input logic [11:0] ir, input logic carry);
    IR        = ir;
    INC_CARRY = carry;
    START     = 1'b1;
    @(negedge SYSCLK);
    START = 1'b0;
    IR    = 12'($urandom_range(0, 4095));
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (outs != 13'h0 || DBG_STATE != 3'd0) begin
      errors++;
      $display("FAIL %s: got out=%b state=%0d, expected out=0 state=0", name, outs, DBG_STATE);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  initial begin
    repeat (3) @(negedge SYSCLK);
    check_idle("reset");
    CLEAR_N = 1'b1;
    gap(2);
    check_idle("post_reset_idle");

    // CLA
    c0 = cyc;
    push(c0, 1, M_BUSY | M_CLR);
    push(c0, 2, M_BUSY | M_CLR | M_ACK);
    push(c0, 3, M_BUSY | M_DONE);
    issue(12'o7200, 1'b0);
    gap(4);

    // CLL CML
    c0 = cyc;
    push(c0, 1, M_BUSY | M_CLL);
    push(c0, 2, M_BUSY | M_CLL | M_LK);
    push(c0, 3, M_BUSY | M_CML);
    push(c0, 4, M_BUSY | M_CML | M_LK);
    push(c0, 5, M_BUSY | M_DONE);
    issue(12'o7120, 1'b0);
    gap(6);

    // IAC with carry
    c0 = cyc;
    push(c0, 1, M_BUSY | M_INC);
    push(c0, 2, M_BUSY | M_INC | M_CML | M_ACK | M_LK);
    push(c0, 3, M_BUSY | M_DONE);
    issue(12'o7001, 1'b1);
    gap(4);

    // IAC without carry
    c0 = cyc;
    push(c0, 1, M_BUSY | M_INC);
    push(c0, 2, M_BUSY | M_INC | M_ACK);
    push(c0, 3, M_BUSY | M_DONE);
    issue(12'o7001, 1'b0);
    gap(4);

    // RTL
    c0 = cyc;
    push(c0, 1, M_BUSY | M_ROTL | M_SET);
    push(c0, 2, M_BUSY | M_ROTL | M_SET | M_ACK | M_LK);
    push(c0, 3, M_BUSY | M_ROTL | M_SET);
    push(c0, 4, M_BUSY | M_ROTL | M_SET | M_ACK | M_LK);
    push(c0, 5, M_BUSY | M_DONE);
    issue(12'o7006, 1'b0);
    gap(6);

    // RAR
    c0 = cyc;
    push(c0, 1, M_BUSY | M_ROTR | M_SET);
    push(c0, 2, M_BUSY | M_ROTR | M_SET | M_ACK | M_LK);
    push(c0, 3, M_BUSY | M_DONE);
    issue(12'o7010, 1'b0);
    gap(4);

    // BSW
    c0 = cyc;
    push(c0, 1, M_BUSY | M_BSW);
    push(c0, 2, M_BUSY | M_BSW | M_ACK);
    push(c0, 3, M_BUSY | M_DONE);
    issue(12'o7002, 1'b0);
    gap(4);

    // RAR+RAL: no step at all
    c0 = cyc;
    push(c0, 1, M_BUSY | M_DONE);
    issue(12'o7014, 1'b0);
    gap(3);

    // not a group 1 opcode
    c0 = cyc;
    push(c0, 1, M_BUSY | M_DONE);
    issue(12'o7401, 1'b0);
    gap(3);

    // longest sequence: CLA CLL CMA CML IAC RTL
    c0 = cyc;
    push(c0, 1,  M_BUSY | M_CLR | M_CLL);
    push(c0, 2,  M_BUSY | M_CLR | M_CLL | M_ACK | M_LK);
    push(c0, 3,  M_BUSY | M_CMA | M_CML);
    push(c0, 4,  M_BUSY | M_CMA | M_CML | M_ACK | M_LK);
    push(c0, 5,  M_BUSY | M_INC);
    push(c0, 6,  M_BUSY | M_INC | M_ACK);
    push(c0, 7,  M_BUSY | M_ROTL | M_SET);
    push(c0, 8,  M_BUSY | M_ROTL | M_SET | M_ACK | M_LK);
    push(c0, 9,  M_BUSY | M_ROTL | M_SET);
    push(c0, 10, M_BUSY | M_ROTL | M_SET | M_ACK | M_LK);
    push(c0, 11, M_BUSY | M_DONE);
    issue(12'o7367, 1'b0);
    gap(12);

    // CLA CLL, then a second START one cycle later that must be dropped
    c0 = cyc;
    push(c0, 1, M_BUSY | M_CLR | M_CLL);
    push(c0, 2, M_BUSY | M_CLR | M_CLL | M_ACK | M_LK);
    push(c0, 3, M_BUSY | M_DONE);
    issue(12'o7300, 1'b0);
    issue(12'o7001, 1'b1);
    gap(5);

    // back-to-back: new START in the DONE cycle
    c0 = cyc;
    push(c0, 1, M_BUSY | M_CLR);
    push(c0, 2, M_BUSY | M_CLR | M_ACK);
    push(c0, 3, M_BUSY | M_DONE);
    issue(12'o7200, 1'b0);
    gap(2);
    c1 = cyc;
    push(c1, 1, M_BUSY | M_BSW);
    push(c1, 2, M_BUSY | M_BSW | M_ACK);
    push(c1, 3, M_BUSY | M_DONE);
    issue(12'o7002, 1'b0);
    gap(4);

    // reset in the middle of a sequence
    c0 = cyc;
    push(c0, 1, M_BUSY | M_CLR);
    issue(12'o7200, 1'b0);
    CLEAR_N = 1'b0;
    @(negedge SYSCLK);
    check_idle("mid_reset");
    CLEAR_N = 1'b1;
    gap(3);
    check_idle("after_abort_idle");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected events, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opr1_sequencer.md
# opr1_sequencer

Sequencer for PDP-8 Operate Group 1 microinstructions. It sits between the instruction decoder and the AC/link/rotater datapath. It orders the micro-operations into the fixed PDP-8 event sequence: clear, then complement, then increment, then rotate. For each step it generates the control levels and the one-cycle AC_CK/LINK_CK strobes that the link register and AC consume.

## Interface
Parameters: none.
- SYSCLK  in  1  system clock; all state changes on rising edge
- CLEAR_N  in  1  reset; synchronous and active-low, same clock
- START  in  1  one-cycle request; IR is valid in the same cycle
- IR  in  12  instruction register; IR[11] is PDP bit 0
- INC_CARRY  in  1  carry-out of the AC incrementer, from the current AC
- BUSY  out  1  high from the cycle after an accepted START until DONE
- DONE  out  1  one-cycle completion pulse
- AC_CLR, AC_CMA, AC_INC  out  1 each  AC operation selects
- ROT_R, ROT_L, ROT_BSW  out  1 each  rotater mode selects
- CLL, CML, SET  out  1 each  link controls
- AC_CK, LINK_CK  out  1 each  AC and link load strobes

## Operation
- Decode at START. Legal only when IR[11:8]=4'b1110.
  - Step CLR is enabled by CLA=IR[7] or CLL=IR[6].
  - Step CMP is enabled by CMA=IR[5] or CML=IR[4].
  - Step INC is enabled by IAC=IR[0].
  - Rotate steps:
    - RAR=IR[3] alone: ROT1 right.
    - RAL=IR[2] alone: ROT1 left.
    - Add ROT2 in the same direction when IR[1]=1.
    - IR[1] with neither RAR nor RAL: single BSW step.
    - RAR and RAL both set: no rotate step.
- The decoded IR is registered at START acceptance. Later IR changes have no effect.
- States are IDLE, CLR, CMP, INC, ROT1, ROT2, FIN.
  - Each step state has two phases. SETUP drives the control levels with strobes low. STROBE holds the same levels and raises AC_CK and/or LINK_CK.
  - From IDLE or after STROBE, go to the next enabled step in order. Disabled steps cost zero cycles. After the last enabled step, go to FIN.
  - FIN asserts DONE for one cycle, drops BUSY and returns to IDLE.
- Controls per step:
  - CLR: AC_CLR=CLA, CLL=IR[6]. AC_CK if CLA; LINK_CK if IR[6].
  - CMP: AC_CMA=CMA, CML=IR[4]. AC_CK if CMA; LINK_CK if IR[4].
  - INC: AC_INC=1. INC_CARRY is sampled at the end of SETUP and drives CML in STROBE. AC_CK=1 always; LINK_CK=1 only when the captured carry is 1.
  - ROT1/ROT2: ROT_R or ROT_L, SET=1, AC_CK=1, LINK_CK=1.
  - BSW: ROT_BSW=1, SET=0, AC_CK=1, LINK_CK=0 (link unchanged).
- Within one step, CLL and CML are never both high.
- Illegal IR or no enabled step: go straight to FIN. DONE pulses the cycle after START with no strobes.
- START while BUSY is ignored. No queueing.

## Timing
- Reset value: every output is 0 and the state is IDLE. This takes effect on the first edge with CLEAR_N=0.
- Reset mid-sequence aborts the sequence. Any strobe that was high drops at the next edge.
- Latency: BUSY rises at the edge after START. The sequence takes 2 cycles per enabled step, then 1 FIN cycle carrying DONE.
  - Maximum: CLA CLL CMA CML IAC RTL gives 5 steps, i.e. 10+1 cycles.
- A START in the same cycle as DONE is accepted, with back-to-back operation.
- All control levels are stable for the whole SETUP+STROBE pair. Strobes are registered, glitch-free outputs.

## Structure
- pdp8_pkg holds:
  - the state enum;
  - localparams for the IR bit positions: CLA, CLL, CMA, CML, RAR, RAL, BSW, IAC;
  - the group-1 opcode constant.
- Sub-module opr1_decode (combinational) maps IR to the step-enable vector plus direction and twice flags.
- opr1_sequencer contains the registered decode, the FSM, the phase bit, the carry capture and the output registers.

## Test plan
- IR=7200 (CLA), START → AC_CLR+AC_CK in STROBE at cycle 2, DONE at cycle 3, LINK_CK never high.
- IR=7120 (CLL CML) → CLR step with CLL+LINK_CK, then CMP step with CML+LINK_CK; DONE at cycle 5.
- IR=7001 (IAC):
  - INC_CARRY=1 → LINK_CK with CML in STROBE.
  - INC_CARRY=0 → AC_CK only.
  - DONE at cycle 3 in both cases.
- IR=7006 (RTL) → two ROT_L steps, each with SET=1, AC_CK=1 and LINK_CK=1; DONE at cycle 5.
- IR=7002 (BSW) → ROT_BSW with AC_CK only. IR=7014 (RAR+RAL) → DONE at cycle 1, no strobes.
- IR=7300 with START, then a second START at cycle 1 → second START ignored. Separately, CLEAR_N=0 at cycle 1 → all outputs 0 at cycle 2 and state is IDLE.
